// File: rtl/demux1to4_buf.sv
// One-to-four demultiplexer. Each output channel is a one-entry buffer with its own
// valid/ready handshake and a modulo-256 counter of words handed to its consumer.
module demux1to4_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_addr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [3:0]       r_state;
  logic [WIDTH-1:0] r_data [4];
  logic [7:0]       r_cnt  [4];

  logic             w_accept;
  logic [3:0]       w_load;
  logic [3:0]       w_deliver;

  // A full channel can still take a new word when its consumer drains it on the same edge.
  assign in_ready  = (r_state[in_addr] == EMPTY) | out_ready[in_addr];
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = r_state & out_ready;

  always_comb begin
    w_load = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_load[k] = w_accept && (in_addr == 2'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= {4{EMPTY}};
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
        r_cnt[k]  <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_state[k] <= FULL;
          r_data[k]  <= in_data;
        end else if (w_deliver[k]) begin
          r_state[k] <= EMPTY;
        end
        if (w_deliver[k]) begin
          r_cnt[k] <= r_cnt[k] + 8'd1;
        end
      end
    end
  end

  assign out_valid = r_state;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign cnt0      = r_cnt[0];
  assign cnt1      = r_cnt[1];
  assign cnt2      = r_cnt[2];
  assign cnt3      = r_cnt[3];

endmodule

// File: doc/demux1to4_buf.md
DEMUX1TO4_BUF -- requirements
Module: demux1to4_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width of the input and of each output channel.
REQ-002 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_data  input  WIDTH  word to route.
REQ-005 SHALL have in_addr  input  2  destination channel select (0..3).
REQ-006 SHALL have in_valid  input  1  producer offers in_data/in_addr.
REQ-007 SHALL have in_ready  output  1  block accepts the offered word this cycle.
REQ-008 SHALL have out_data0..out_data3  output  WIDTH each  per-channel held word.
REQ-009 SHALL have out_valid  output  4  bit k set means channel k holds a word.
REQ-010 SHALL have out_ready  input  4  bit k set means the consumer of channel k takes the word this cycle.
REQ-011 SHALL have cnt0..cnt3  output  8 each  per-channel delivered-word counters.

Function
REQ-012 SHALL implement each channel k as a one-entry buffer with two states:
- EMPTY (out_valid[k]=0)
- FULL (out_valid[k]=1)
REQ-013 SHALL drive in_ready combinationally as ~out_valid[in_addr] | out_ready[in_addr]; in_ready SHALL NOT depend on in_valid.
REQ-014 SHALL accept a word when in_valid & in_ready at a rising edge. On accept, out_data[in_addr] <= in_data and out_valid[in_addr] <= 1.
REQ-015 SHALL deliver channel k when out_valid[k] & out_ready[k] at a rising edge. On delivery, cnt_k increments by 1, wrapping 255 -> 0.
REQ-016 SHALL clear out_valid[k] on delivery unless the same edge also accepts into channel k.
REQ-017 SHALL, on simultaneous delivery and accept on channel k, load the new word and keep out_valid[k]=1 with no bubble; the old word counts as delivered.
REQ-018 SHALL have a latency of exactly one cycle from accept to out_valid asserted with the new out_data.
REQ-019 SHALL leave out_data[k] unchanged when channel k is neither loaded nor, for the valid bit, delivered; out_data[k] keeps its last value after delivery.
REQ-020 SHALL leave channels other than in_addr unaffected by an accept, while allowing them to deliver independently on the same edge.
REQ-021 SHALL ignore out_ready[k] while out_valid[k]=0: no count, no state change.
REQ-022 SHALL treat in_valid=0 as no accept, regardless of in_ready.
REQ-023 SHALL require the producer to hold in_data and in_addr stable while in_valid & ~in_ready; the bench SHALL flag violations, and the block's behaviour under a violation is undefined.
REQ-024 SHALL keep cnt_k a modulo-256 count; overflow SHALL NOT affect routing.

Reset
REQ-025 SHALL, while rst_n=0 and regardless of clk, force out_valid=4'b0000, out_data0..3=0 and cnt0..3=0.
REQ-026 SHALL drive in_ready=1 during and immediately after reset, since all channels are EMPTY.
REQ-027 SHALL discard, on a reset asserted mid-transfer, any word being accepted on that edge and all buffered words; no delivery is counted.
REQ-028 SHALL take the first accept on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-029 Basic routing: reset, then in_valid=1, in_addr=2, in_data=32'hDEADBEEF, out_ready=4'b0000 for one edge -> next cycle out_valid=4'b0100, out_data2=32'hDEADBEEF, cnt2=0, out_data0/1/3=0.
REQ-030 Backpressure: channel 2 FULL, out_ready[2]=0, in_addr=2, in_data=32'h1 -> in_ready=0 and out_data2 is unchanged over 3 cycles; then out_ready[2]=1 -> in_ready=1, and at that edge out_data2=32'h1, out_valid[2] stays 1, cnt2=1.
REQ-031 Parallel channels: channel 0 FULL with out_ready=4'b0001; accept into channel 3 with data 32'hA5 on the same edge -> out_valid=4'b1000, cnt0=1, out_data3=32'hA5.
REQ-032 Streaming throughput: out_ready[1]=1 held; 10 consecutive accepts into channel 1 with data 1..10 -> in_ready=1 every cycle, out_data1 follows with one-cycle lag, and cnt1=10 one cycle after the last accept.
REQ-033 Counter wrap: 256 deliveries on channel 0 -> cnt0 reads 255, then 0; routing unaffected.
REQ-034 Async reset: assert rst_n=0 between clock edges with out_valid=4'b1111 -> outputs and counters go to 0 immediately without a clock edge, and in_ready=1.
